cipher_block_unpacker: RTL and testbench
========================================

Name: cipher_block_unpacker

Overview:
- Sink-side counterpart of the block-level datapath: consumes 256-bit blocks from the CTR Feistel decrypt core, or from encrypt for the ciphertext tap.
- Those blocks arrive as single-cycle valid pulses with no backpressure.
- Buffers the blocks and re-serialises them into an 8-bit pixel stream with valid/ready handshake plus block-end and frame-end markers, for image write-back.
- Drops blocks it cannot hold and flags the loss.

Parameters:
- DATA_WIDTH, 256, block width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, output pixel width; equals SBOX_WIDTH.
- DEPTH, 2, number of block slots; power of 2, ≥2.
- FRAME_BLOCKS, 4, blocks per frame; governs m_last; ≥1.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- s_valid  input  1  one-cycle pulse; s_data valid this cycle
- s_data  input  DATA_WIDTH  block from the crypto core
- m_valid  output  1  m_data holds a valid pixel
- m_ready  input  1  downstream accepts the pixel
- m_data  output  BYTE_WIDTH  pixel, MSB byte of the block first
- m_last_byte  output  1  last pixel of the current block
- m_last  output  1  last pixel of the last block in a frame
- occupancy  output  $clog2(DEPTH)+1  slots currently holding a block
- overflow  output  1  sticky; a block was dropped
- clear_overflow  input  1  clears overflow

Behaviour:
- Reset, asynchronous: m_valid=0, m_data=0, m_last_byte=0, m_last=0, occupancy=0, overflow=0. Write pointer, read pointer, byte counter and frame counter all go to 0. Buffered data is discarded, including on reset mid-stream.
- Storage: DEPTH×DATA_WIDTH circular buffer. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally.
- Write: s_valid sampled at rising edge N with a free slot stores s_data at wr_ptr, increments wr_ptr, and raises occupancy after edge N.
- Free slot: occupancy<DEPTH, or a pop occurring at the same edge. Simultaneous full-pop and write is accepted.
- Drop: s_valid when full with no pop at that edge discards the block. occupancy is unchanged and overflow is set after the edge.
- overflow: clear_overflow clears it. If clear_overflow and a new drop occur at the same edge, overflow stays 1.
- FSM, two states:
  - IDLE: m_valid=0. Moves to STREAM on the edge after occupancy becomes nonzero.
  - STREAM: m_valid=1.
  - First pixel appears after edge N+1 for a write at edge N into an empty buffer, giving 1-cycle latency.
- Pixel select: m_data = slot[rd_ptr][DATA_WIDTH-1-k*BYTE_WIDTH -: BYTE_WIDTH], where k is the byte counter (0..DATA_WIDTH/BYTE_WIDTH-1, 32 by default). Output is registered, or a mux of registered state; either is acceptable if the timing above holds.
- Handshake:
  - A transfer occurs when m_valid && m_ready at an edge; k increments on each transfer.
  - While m_valid && !m_ready, m_data, m_last_byte and m_last hold stable.
  - m_valid never drops without a transfer.
- Block end: m_last_byte=1 when k=last. Transfer of that pixel is the "pop":
  - rd_ptr++, occupancy--, k←0;
  - frame counter increments and wraps at FRAME_BLOCKS-1;
  - if occupancy becomes 0 and no simultaneous write, FSM goes to IDLE.
- Back-to-back blocks: after a pop with a further block buffered, the next block's first pixel is presented the following cycle with no bubble.
- m_last = m_last_byte && (frame counter == FRAME_BLOCKS-1).
- occupancy changes by at most ±1 per edge; write+pop in the same cycle leaves it unchanged.
- s_data is sampled only on accepted s_valid; its value in other cycles is ignored.

Decomposition:
- Shared package (crypto_pkg): DATA_WIDTH/BYTE_WIDTH defaults, derived BYTES_PER_BLOCK, and the unpacker FSM state enum.
- One sub-module, block_buffer: DEPTH-slot circular store with push/pop/full/empty/occupancy. The unpacker wraps it with the byte counter, frame counter, FSM and overflow logic.

Test Plan:
- Single block, m_ready=1: s_data=256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF.
  - Expect 32 pixels 11,22,…,DD,EE,FF, first one cycle after the write.
  - m_last_byte only on the final 8'hFF; m_valid then falls.
- Backpressure: same block, m_ready toggling 1,0,0,1…
  - Pixel order is unchanged and m_data stays stable during stalls.
  - Exactly 32 transfers occur.
- Overflow: three s_valid pulses on consecutive cycles with m_ready=0.
  - occupancy=2 and overflow=1; the third block is absent from the output.
  - clear_overflow clears it; clear concurrent with a new drop keeps it at 1.
- Full + pop: buffer full, m_ready=1, s_valid pulsed at the edge of the last pixel.
  - Block accepted, occupancy stays 2, overflow stays 0.
  - No bubble between blocks.
- Frame marking: 5 blocks with FRAME_BLOCKS=4.
  - m_last only on the last pixel of block 4.
  - Block 5's last pixel has m_last_byte=1, m_last=0.
- Reset mid-stream: assert reset_n=0 at pixel 10 of block 1 with block 2 buffered.
  - All outputs are 0 immediately.
  - After release, a new block streams from byte 0 with frame counter 0.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared widths and state encoding for the block-level crypto datapath.
package crypto_pkg;

   localparam int DEF_DATA_WIDTH  = 256;
   localparam int DEF_BYTE_WIDTH  = 8;
   localparam int BYTES_PER_BLOCK = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } unpack_state_e;

   // Counter width that stays legal when the modulus is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/block_buffer.sv
// DEPTH-slot circular block store; rd_data always shows the oldest slot.
module block_buffer
   import crypto_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: ;
         endcase
      end
   end

   // Payload needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (occupancy == OW'(DEPTH));
   assign empty   = (occupancy == '0);

endmodule

// File: rtl/cipher_block_unpacker.sv
// Buffers cipher blocks arriving as unthrottled pulses and replays them as a
// byte stream, MSB byte first, with block-end and frame-end markers.
module cipher_block_unpacker
   import crypto_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH,
   parameter int DEPTH        = 2,
   parameter int FRAME_BLOCKS = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       s_valid,
   input  logic [DATA_WIDTH-1:0]      s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [BYTE_WIDTH-1:0]      m_data,
   output logic                       m_last_byte,
   output logic                       m_last,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int KW     = cnt_width(NBYTES);
   localparam int FW     = cnt_width(FRAME_BLOCKS);
   localparam int OW     = $clog2(DEPTH) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FRAME_BLOCKS - 1);

   unpack_state_e state, state_nxt;

   logic [KW-1:0]                     k;
   logic [FW-1:0]                     frame_cnt;
   logic                              push, pop, xfer, at_last, full, empty;
   logic [DATA_WIDTH-1:0]             rd_data;
   logic [NBYTES-1:0][BYTE_WIDTH-1:0] rd_bytes;

   assign xfer    = m_valid && m_ready;
   assign at_last = (k == K_LAST);
   assign pop     = xfer && at_last;
   // A pop frees the slot at the same edge, so a full buffer still accepts.
   assign push    = s_valid && (!full || pop);

   block_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .wr_data   (s_data),
      .rd_data   (rd_data),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      m_valid   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            m_valid = 1'b1;
            if (pop && (occupancy == OW'(1)) && !push) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k         <= '0;
         frame_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (pop)       k <= '0;
         else if (xfer) k <= k + 1'b1;
         if (pop) frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + 1'b1;
         // A fresh drop wins over a concurrent clear.
         if (s_valid && !push)    overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   assign rd_bytes    = rd_data;
   assign m_data      = m_valid ? rd_bytes[K_LAST - k] : '0;
   assign m_last_byte = m_valid && at_last;
   assign m_last      = m_last_byte && (frame_cnt == F_LAST);

endmodule

// File: tb/tb_cipher_block_unpacker.sv
// Directed bench for cipher_block_unpacker: streaming, stalls, drops, frames, reset.
module tb_cipher_block_unpacker;

   localparam logic [255:0] B0 =
      256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;
   localparam logic [255:0] B1 =
      256'h0102030405060708090a0b0c0d0e0f10_1112131415161718191a1b1c1d1e1f20;
   localparam logic [255:0] B2 =
      256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf_b0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
   localparam logic [255:0] B3 =
      256'hf0e1d2c3b4a5968778695a4b3c2d1e0f_0f1e2d3c4b5a69788796a5b4c3d2e1f0;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         s_valid;
   logic [255:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [7:0]   m_data;
   logic         m_last_byte;
   logic         m_last;
   logic [1:0]   occupancy;
   logic         overflow;
   logic         clear_overflow;

   int checks = 0;
   int errors = 0;
   int fcnt   = 0;
   int w;

   cipher_block_unpacker dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last_byte    (m_last_byte),
      .m_last         (m_last),
      .occupancy      (occupancy),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [255:0] b, input int idx);
      logic [255:0] t;
      t = b >> (8 * (31 - idx));
      return t[7:0];
   endfunction

   // One-cycle pulse; s_data is scrambled afterwards since it must be ignored.
   task automatic send(input logic [255:0] b);
      s_valid = 1'b1;
      s_data  = b;
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = ~b;
   endtask

   // Consume one block; mode 0 = always ready, mode 1 = ready pattern 1,0,0.
   // Returns at the negedge before the final transfer edge.
   task automatic recv(input logic [255:0] b, input bit lastf, input int mode,
                       input bit inject, input logic [255:0] inj, output int wait_cyc);
      int idx = 0;
      int cyc = 0;
      wait_cyc = 0;
      while (idx < 32) begin
         if (cyc > 400) begin
            chk("timeout", 64'(idx), 64'd32);
            return;
         end
         m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (m_valid) begin
            chk("data", m_data, byte_of(b, idx));
            chk("last_byte", m_last_byte, idx == 31);
            chk("last", m_last, lastf && (idx == 31));
            if (m_ready) begin
               if (inject && idx == 31) begin
                  s_valid = 1'b1;
                  s_data  = inj;
               end
               idx++;
            end
         end else begin
            if (idx > 0) chk("valid_drop", m_valid, 1'b1);
            else         wait_cyc++;
         end
         cyc++;
         if (idx < 32) @(negedge clk);
      end
      fcnt = (fcnt + 1) % 4;
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      s_valid        = 1'b0;
      clear_overflow = 1'b0;
      m_ready        = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      fcnt    = 0;
   endtask

   initial begin
      reset_n        = 1'b0;
      s_valid        = 1'b0;
      s_data         = '0;
      m_ready        = 1'b0;
      clear_overflow = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_data", m_data, 8'h00);
      chk("rst_lastb", m_last_byte, 1'b0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_occ", occupancy, 2'd0);
      chk("rst_ovf", overflow, 1'b0);
      reset_n = 1'b1;

      // single block, always ready
      m_ready = 1'b1;
      send(B0);
      chk("t1_valid_early", m_valid, 1'b0);
      chk("t1_occ", occupancy, 2'd1);
      recv(B0, fcnt == 3, 0, 1'b0, '0, w);
      chk("t1_latency", 64'(w), 64'd1);
      @(negedge clk);
      chk("t1_valid_end", m_valid, 1'b0);
      chk("t1_occ_end", occupancy, 2'd0);

      // backpressure
      send(B0);
      recv(B0, fcnt == 3, 1, 1'b0, '0, w);
      @(negedge clk);
      chk("t2_valid_end", m_valid, 1'b0);

      // overflow: third consecutive block dropped
      m_ready = 1'b0;
      send(B1);
      send(B2);
      send(B3);
      chk("t3_occ", occupancy, 2'd2);
      chk("t3_ovf", overflow, 1'b1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk("t3_clear", overflow, 1'b0);
      s_valid = 1'b1;
      s_data = B0;
      clear_overflow = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      clear_overflow = 1'b0;
      chk("t3_clear_vs_drop", overflow, 1'b1);
      chk("t3_occ2", occupancy, 2'd2);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      chk("t3_clear2", overflow, 1'b0);
      recv(B1, fcnt == 3, 0, 1'b0, '0, w);
      @(negedge clk);
      recv(B2, fcnt == 3, 0, 1'b0, '0, w);
      @(negedge clk);
      chk("t3_no_third", m_valid, 1'b0);
      chk("t3_occ_end", occupancy, 2'd0);

      // full buffer, write concurrent with pop
      m_ready = 1'b0;
      send(B1);
      send(B2);
      chk("t4_full", occupancy, 2'd2);
      recv(B1, fcnt == 3, 0, 1'b1, B3, w);
      @(negedge clk);
      s_valid = 1'b0;
      chk("t4_occ", occupancy, 2'd2);
      chk("t4_ovf", overflow, 1'b0);
      recv(B2, fcnt == 3, 0, 1'b0, '0, w);
      chk("t4_no_bubble", 64'(w), 64'd0);
      @(negedge clk);
      recv(B3, fcnt == 3, 0, 1'b0, '0, w);
      chk("t4_no_bubble2", 64'(w), 64'd0);
      @(negedge clk);
      chk("t4_occ_end", occupancy, 2'd0);

      // frame marking over five blocks
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send((i % 2) ? B2 : B1);
         recv((i % 2) ? B2 : B1, i == 3, 0, 1'b0, '0, w);
         @(negedge clk);
      end

      // reset mid-stream with a second block buffered
      do_reset();
      send(B1);
      send(B2);
      send(B3);
      chk("t6_ovf_pre", overflow, 1'b1);
      m_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_pix10", m_data, byte_of(B1, 10));
      m_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t6_valid", m_valid, 1'b0);
      chk("t6_data", m_data, 8'h00);
      chk("t6_lastb", m_last_byte, 1'b0);
      chk("t6_last", m_last, 1'b0);
      chk("t6_occ", occupancy, 2'd0);
      chk("t6_ovf", overflow, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      fcnt = 0;
      m_ready = 1'b1;
      send(B3);
      recv(B3, 1'b0, 0, 1'b0, '0, w);
      chk("t6_latency", 64'(w), 64'd1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         send(B0);
         recv(B0, i == 2, 0, 1'b0, '0, w);
         @(negedge clk);
      end
      chk("t6_idle", m_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
